pcie_130b_tx_gearbox: RTL and testbench

//  Tx gearbox directly downstream of the 128b/130b encoder.
//  - Accepts 130-bit encoded blocks (sync header in bits [1:0]).
//  - Repacks them into a continuous OUT_W-bit word stream for the serializer/PMA.
//  - Valid/ready on both sides; upstream is stalled as the bit-rate ratio requires
//    (OUT_W=32: 16 blocks per 65 words).

---
 rtl/pcie_130b_tx_gearbox_if.sv | 24 ++
 rtl/pcie_130b_tx_gearbox.sv | 128 ++++++++++++
 tb/tb_pcie_130b_tx_gearbox.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_130b_tx_gearbox_if.sv
// Block/word handshake bundle between the 128b/130b encoder, the Tx gearbox and the serializer.
// master = encoder/serializer side, slave = gearbox.
interface pcie_130b_tx_gearbox_if #(
    parameter int OUT_W = 32
);
    logic [129:0]     in_block;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_word;
    logic             out_valid;
    logic             out_ready;
    logic             out_underrun;
    logic             err_sync_hdr;

    modport master (
        output in_block, in_valid, out_ready,
        input  in_ready, out_word, out_valid, out_underrun, err_sync_hdr
    );

    modport slave (
        input  in_block, in_valid, out_ready,
        output in_ready, out_word, out_valid, out_underrun, err_sync_hdr
    );
endinterface

// File: rtl/pcie_130b_tx_gearbox.sv
// 130-bit block to OUT_W-bit word Tx gearbox; oldest bit always sits at buf_q[0].
// Optional sync-header checker enabled by macro GEARBOX_SYNC_CHECK_EN.
module pcie_130b_tx_gearbox #(
    parameter int OUT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pcie_130b_tx_gearbox_if.slave       bus
);
    localparam int BLK_W  = 130;
    localparam int BUF_W  = 2 * OUT_W - 1 + BLK_W;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [BUF_W-1:0] BLK_MASK = {{(BUF_W-BLK_W){1'b0}}, {BLK_W{1'b1}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    logic [BUF_W-1:0]  buf_q, buf_d, shifted_s;
    logic [FILL_W-1:0] fill_q, fill_d, base_s;
    state_e            state_q, state_d;
    logic              underrun_q, underrun_d;
    logic              out_valid_s, in_ready_s, pop_s, acc_s;

    assign out_valid_s      = (fill_q >= FILL_W'(OUT_W));
    assign in_ready_s       = (fill_q <  FILL_W'(2 * OUT_W));
    assign pop_s            = out_valid_s & bus.out_ready;
    assign acc_s            = bus.in_valid & in_ready_s;

    assign bus.out_valid    = out_valid_s;
    assign bus.in_ready     = in_ready_s;
    assign bus.out_word     = buf_q[OUT_W-1:0];
    assign bus.out_underrun = underrun_q;

    // Pack/unpack datapath: shift out a word on pop, then drop the new block right above the survivors
    always_comb begin
        shifted_s = buf_q;
        base_s    = fill_q;
        if (pop_s) begin
            shifted_s = buf_q >> OUT_W;
            base_s    = fill_q - FILL_W'(OUT_W);
        end else begin
            shifted_s = buf_q;
            base_s    = fill_q;
        end
        buf_d  = shifted_s;
        fill_d = base_s;
        if (acc_s) begin
            buf_d  = (shifted_s & ~(BLK_MASK << base_s))
                   | ({{(BUF_W-BLK_W){1'b0}}, bus.in_block} << base_s);
            fill_d = base_s + FILL_W'(BLK_W);
        end else begin
            buf_d  = shifted_s;
            fill_d = base_s;
        end
    end

    // Run-state tracking and starvation detect; IDLE masks underrun until the link first drains a word
    always_comb begin
        state_d    = state_q;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                state_d    = ST_RUN;
                underrun_d = bus.out_ready & ~out_valid_s;
            end
            default: begin
                state_d    = ST_IDLE;
                underrun_d = 1'b0;
            end
        endcase
    end

    // Core state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            fill_q     <= '0;
            state_q    <= ST_IDLE;
            underrun_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            state_q    <= state_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef GEARBOX_SYNC_CHECK_EN
    logic err_q, err_d;

    function automatic logic bad_sync_hdr(input logic [1:0] hdr);
        return (hdr == 2'b00) || (hdr == 2'b11);
    endfunction

    // Flag an illegal header on the accepted block; the block itself is still packed unchanged
    always_comb begin
        err_d = 1'b0;
        if (acc_s) begin
            err_d = bad_sync_hdr(bus.in_block[1:0]);
        end else begin
            err_d = 1'b0;
        end
    end

    // Header error pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_sync_hdr = err_q;
`else
    assign bus.err_sync_hdr = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_130b_tx_gearbox.sv
// Randomized bench for pcie_130b_tx_gearbox against a bit-queue model of the serial stream.
module tb_pcie_130b_tx_gearbox;
    localparam int OUT_W = 32;
    localparam int BLK_W = 130;
`ifdef GEARBOX_SYNC_CHECK_EN
    localparam int EXP_ERRS = 2;
`else
    localparam int EXP_ERRS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pcie_130b_tx_gearbox_if #(.OUT_W(OUT_W)) bus ();
    pcie_130b_tx_gearbox #(.OUT_W(OUT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;
    bit mq[$];
    bit running, exp_und, exp_err, last_acc;
    int n_acc;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [129:0] new_block(input logic [1:0] hdr);
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        r[1:0] = hdr;
        return r[129:0];
    endfunction

    function automatic logic [1:0] good_hdr();
        logic [1:0] h;
        h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        return h;
    endfunction

    task automatic check_outputs();
        logic [63:0] w;
        check_val("out_valid", bus.out_valid, 64'(mq.size() >= OUT_W));
        check_val("in_ready", bus.in_ready, 64'(mq.size() < 2 * OUT_W));
        check_val("out_underrun", bus.out_underrun, 64'(exp_und));
        check_val("err_sync_hdr", bus.err_sync_hdr, 64'(exp_err));
        if (mq.size() >= OUT_W) begin
            w = '0;
            for (int i = 0; i < OUT_W; i++) w[i] = mq[i];
            check_val("out_word", 64'(bus.out_word), w);
        end
    endtask

    // One clock: predict from the serial-stream model, advance, compare
    task automatic cycle();
        bit pop, acc, nu, ne;
        pop = (mq.size() >= OUT_W) && bus.out_ready;
        acc = bus.in_valid && (mq.size() < 2 * OUT_W);
        nu  = running && bus.out_ready && (mq.size() < OUT_W);
`ifdef GEARBOX_SYNC_CHECK_EN
        ne  = acc && (bus.in_block[1:0] == 2'b00 || bus.in_block[1:0] == 2'b11);
`else
        ne  = 1'b0;
`endif
        if (pop) begin
            repeat (OUT_W) void'(mq.pop_front());
            running = 1'b1;
        end
        if (acc) begin
            for (int i = 0; i < BLK_W; i++) mq.push_back(bus.in_block[i]);
            n_acc++;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        exp_und = nu;
        exp_err = ne;
        check_outputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        check_val("rst_out_valid", bus.out_valid, 64'd0);
        check_val("rst_in_ready", bus.in_ready, 64'd1);
        check_val("rst_out_word", 64'(bus.out_word), 64'd0);
        check_val("rst_underrun", bus.out_underrun, 64'd0);
        check_val("rst_err", bus.err_sync_hdr, 64'd0);
        mq.delete();
        running = 1'b0;
        exp_und = 1'b0;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        int words, gaps, lows, pops, unds, errs, idx;
        bit seen;
        logic [OUT_W-1:0] word0;
        logic [1:0] hq [4];

        bus.in_block = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        apply_reset();

        // Reset mid-stream with 98 bits buffered
        bus.in_block = new_block(good_hdr());
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        check_val("fill98_valid", bus.out_valid, 64'd1);
        check_val("fill98_ready", bus.in_ready, 64'd0);
        apply_reset();

        // Backpressure: one block held for 10 stalled cycles
        bus.in_block = new_block(good_hdr());
        bus.in_valid = 1'b1;
        cycle();
        word0 = bus.out_word;
        bus.in_block = new_block(good_hdr());
        for (int c = 0; c < 10; c++) begin
            cycle();
            check_val("stall_word_stable", 64'(bus.out_word), 64'(word0));
            check_val("stall_in_ready", bus.in_ready, 64'd0);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (last_acc) bus.in_block = new_block(good_hdr());
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 20; c++) cycle();

        // Continuous streaming: 16 blocks -> 65 words
        apply_reset();
        n_acc = 0;
        words = 0; gaps = 0; lows = 0; seen = 1'b0;
        bus.in_block = new_block(good_hdr());
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 65; c++) begin
            if (!bus.in_ready) lows++;
            if (bus.out_valid) begin
                words++;
                seen = 1'b1;
            end else if (seen) begin
                gaps++;
            end
            cycle();
            if (last_acc) bus.in_block = new_block(good_hdr());
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 10 && bus.out_valid; c++) begin
            words++;
            cycle();
        end
        check_val("stream_blocks", 64'(n_acc), 64'd16);
        check_val("stream_words", 64'(words), 64'd65);
        check_val("stream_gaps", 64'(gaps), 64'd0);
        check_val("stream_ready_low", 64'(lows), 64'd49);

        // Drain after RUN: underrun while starved, then 4 words + 2 leftover bits
        for (int c = 0; c < 3; c++) cycle();
        check_val("starved_underrun", bus.out_underrun, 64'd1);
        bus.in_block = new_block(good_hdr());
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        pops = 0; unds = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) pops++;
            cycle();
            if (bus.out_underrun) unds++;
        end
        check_val("drain_words", 64'(pops), 64'd4);
        check_val("drain_underruns", 64'(unds), 64'd4);

        // Sync header sequence 01, 11, 10, 00
        hq[0] = 2'b01; hq[1] = 2'b11; hq[2] = 2'b10; hq[3] = 2'b00;
        idx = 0; errs = 0;
        bus.in_block = new_block(hq[0]);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            cycle();
            if (bus.err_sync_hdr) errs++;
            if (last_acc) begin
                idx++;
                if (idx < 4) bus.in_block = new_block(hq[idx]);
            end
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            cycle();
            if (bus.err_sync_hdr) errs++;
        end
        check_val("hdr_blocks", 64'(idx), 64'd4);
        check_val("hdr_err_pulses", 64'(errs), 64'(EXP_ERRS));

        // Random traffic with random headers
        bus.in_block = new_block(2'($urandom_range(0, 3)));
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_acc) bus.in_block = new_block(2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
